// File: rtl/uart_cmd_fsm.sv
// UART register-access master: serializes a {rw,addr,wdata} command as odd-parity
// frames on tx and, for reads, captures one odd-parity response frame from rx.
module uart_cmd_fsm #(
    parameter int CMD_ADDR_WIDTH = 7,
    parameter int CMD_DATA_WIDTH = 8,
    parameter int CMD_RW_FLAG    = 1,
    parameter int CMD_WIDTH      = CMD_ADDR_WIDTH + CMD_DATA_WIDTH + CMD_RW_FLAG,
    parameter int BAUD_DIV       = 434
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    input  logic [CMD_WIDTH-1:0]      cmd_data,
    output logic                      cmd_ready,
    output logic                      read_valid,
    output logic [CMD_DATA_WIDTH-1:0] read_data,
    output logic                      tx,
    input  logic                      rx
);

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_DATA,
        RX_WAIT,
        RX_FRAME
    } state_t;

    localparam int CNT_W      = $clog2(BAUD_DIV);
    localparam int FRAME_BITS = CMD_DATA_WIDTH + 3;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(CMD_DATA_WIDTH);
    localparam logic [IDX_W-1:0] PAR_IDX   = IDX_W'(CMD_DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] STOP_IDX  = IDX_W'(CMD_DATA_WIDTH + 2);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          bit_q, bit_d;
    logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
    logic                      tx_q, tx_d;
    logic [CMD_DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                      rx_par_q, rx_par_d;
    logic [CMD_DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                      read_valid_q, read_valid_d;
    logic                      rx_meta_q, rx_sync_q, rx_prev_q;

    logic [CMD_DATA_WIDTH-1:0] tx_byte;
    logic                      rx_fall;
    logic [CNT_W-1:0]          sample_at;

    // Frame layout, index 0 first on the wire: start, data LSB..MSB, odd parity, stop.
    function automatic logic frame_bit(input logic [CMD_DATA_WIDTH-1:0] b,
                                       input logic [IDX_W-1:0] idx);
        logic [FRAME_BITS-1:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        return f[idx];
    endfunction

    assign tx_byte   = (state_q == TX_CMD) ? cmd_q[CMD_WIDTH-1 -: CMD_DATA_WIDTH]
                                           : cmd_q[CMD_DATA_WIDTH-1:0];
    assign rx_fall   = rx_prev_q & ~rx_sync_q;
    // Start bit is sampled half a bit after the edge, all later bits a full bit apart.
    assign sample_at = (bit_q == '0) ? HALF_LAST : BIT_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            cmd_q        <= '0;
            tx_q         <= 1'b1;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            cmd_q        <= cmd_d;
            tx_q         <= tx_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        cmd_d        = cmd_q;
        tx_d         = tx_q;
        rx_shift_d   = rx_shift_q;
        rx_par_d     = rx_par_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (cmd_valid) begin
                    cmd_d   = cmd_data;
                    state_d = TX_CMD;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end

            TX_CMD, TX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == STOP_IDX) begin
                        bit_d = '0;
                        // The data frame's start bit directly follows the command stop bit.
                        if (state_q == TX_CMD && cmd_q[CMD_WIDTH-1]) begin
                            state_d = TX_DATA;
                            tx_d    = 1'b0;
                        end else if (state_q == TX_CMD) begin
                            state_d = RX_WAIT;
                            tx_d    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + IDX_W'(1);
                        tx_d  = frame_bit(tx_byte, bit_q + IDX_W'(1));
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RX_WAIT: begin
                tx_d = 1'b1;
                if (rx_fall) begin
                    state_d = RX_FRAME;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end

            RX_FRAME: begin
                tx_d = 1'b1;
                if (cnt_q == sample_at) begin
                    cnt_d = '0;
                    bit_d = bit_q + IDX_W'(1);
                    if (bit_q == '0) begin
                        if (rx_sync_q) begin
                            state_d = RX_WAIT;
                            bit_d   = '0;
                        end
                    end else if (bit_q <= DATA_LAST) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[CMD_DATA_WIDTH-1:1]};
                    end else if (bit_q == PAR_IDX) begin
                        rx_par_d = rx_sync_q;
                    end else begin
                        // Stop sample: accept only odd overall parity and a high stop bit.
                        state_d = IDLE;
                        bit_d   = '0;
                        if (rx_sync_q && (^{rx_shift_q, rx_par_q})) begin
                            read_data_d  = rx_shift_q;
                            read_valid_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;
    assign tx         = tx_q;

endmodule

// File: tb/tb_uart_cmd_fsm.sv
// Directed/randomized bench for uart_cmd_fsm: expected tx bit streams and rx
// results come from a frame model built from queues and bit counting.
module tb_uart_cmd_fsm;

    localparam int BAUD = 434;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_data = '0;
    logic        cmd_ready;
    logic        read_valid;
    logic [7:0]  read_data;
    logic        tx;
    logic        rx = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int rv_total = 0;

    uart_cmd_fsm #(.BAUD_DIV(BAUD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .read_valid (read_valid),
        .read_data  (read_data),
        .tx         (tx),
        .rx         (rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (read_valid === 1'b1) rv_total <= rv_total + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_par(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic push_frame(inout logic q[$], input logic [7:0] b, input logic par, input logic stop);
        q.push_back(1'b0);
        for (int k = 0; k < 8; k++) q.push_back(b[k]);
        q.push_back(par);
        q.push_back(stop);
    endtask

    task automatic send_cmd(input logic [15:0] cmd, input bit hold);
        for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) step();
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        step();
        if (!hold) cmd_valid = 1'b0;
        check("ready_low_after_accept", cmd_ready, 0);
    endtask

    // Called right after the accepting edge; checks first and last cycle of every bit.
    task automatic check_frames(input logic [15:0] cmd);
        logic q[$];
        int   nb;
        int   rv0;
        rv0 = rv_total;
        push_frame(q, cmd[15:8], odd_par(cmd[15:8]), 1'b1);
        if (cmd[15]) push_frame(q, cmd[7:0], odd_par(cmd[7:0]), 1'b1);
        nb = q.size();
        for (int i = 0; i < nb * BAUD; i++) begin
            if (i % BAUD == 0 || i % BAUD == BAUD - 1)
                check($sformatf("tx_bit%0d_c%0d", i / BAUD, i % BAUD), tx, q[i / BAUD]);
            if (i % BAUD == BAUD / 2)
                check("ready_busy", cmd_ready, 0);
            step();
        end
        check("tx_after_frames", tx, 1);
        check("ready_after_frames", cmd_ready, cmd[15] ? 1 : 0);
        if (cmd[15]) check("no_rv_on_write", rv_total, rv0);
        $display("cmd %h: %0d tx bits checked over %0d cycles", cmd, nb, nb * BAUD);
    endtask

    // Drives one rx frame starting now; returns pulse count, first pulse cycle, ready at pulse.
    task automatic drive_rx(input logic [7:0] b, input logic par, output int pulses,
                            output int first, output logic rdy);
        logic q[$];
        push_frame(q, b, par, 1'b1);
        pulses = 0;
        first  = -1;
        rdy    = 1'b0;
        for (int c = 0; c < 11 * BAUD + 20; c++) begin
            rx = (c < 11 * BAUD) ? q[c / BAUD] : 1'b1;
            step();
            if (read_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c + 1;
                    rdy   = cmd_ready;
                end
            end
        end
        rx = 1'b1;
    endtask

    task automatic expect_good_rx(input logic [7:0] b);
        int pulses, first;
        logic rdy;
        drive_rx(b, odd_par(b), pulses, first, rdy);
        check("rv_pulse_count", pulses, 1);
        check("rv_timing_window", (first >= 4555 && first <= 4565) ? 1 : 0, 1);
        check("ready_with_rv", rdy, 1);
        check("read_data", read_data, b);
        check("ready_after_rx", cmd_ready, 1);
        $display("rx byte %h: pulses=%0d at cycle %0d read_data=%h", b, pulses, first, read_data);
    endtask

    initial begin
        logic [15:0] c1, c2;
        logic [7:0]  rb;
        int          pulses, first, rv0;
        logic        rdy;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", cmd_ready, 1);
        check("rst_read_valid", read_valid, 0);
        check("rst_read_data", read_data, 0);
        rst_n = 1'b1;
        step();

        // Write {1,100,AB}
        send_cmd({1'b1, 7'd100, 8'hAB}, 0);
        check_frames({1'b1, 7'd100, 8'hAB});
        check("write_read_data_kept", read_data, 0);

        // Read {0,100,00}, good 0x35 response after 100 idle cycles
        send_cmd({1'b0, 7'd100, 8'h00}, 0);
        check_frames({1'b0, 7'd100, 8'h00});
        repeat (100) step();
        check("waiting_for_rx", cmd_ready, 0);
        expect_good_rx(8'h35);

        // Read with bad-parity response
        send_cmd({1'b0, 7'd5, 8'h00}, 0);
        check_frames({1'b0, 7'd5, 8'h00});
        repeat (50) step();
        drive_rx(8'h35, 1'b0, pulses, first, rdy);
        check("badpar_no_rv", pulses, 0);
        check("badpar_data_kept", read_data, 8'h35);
        check("badpar_ready", cmd_ready, 1);
        $display("bad parity frame: pulses=%0d read_data=%h", pulses, read_data);

        // Glitch in RX_WAIT, then a random valid frame
        c1 = {1'b0, 7'($urandom_range(0, 127)), 8'h00};
        rb = 8'($urandom_range(0, 255));
        send_cmd(c1, 0);
        check_frames(c1);
        rv0 = rv_total;
        rx = 1'b0;
        repeat (100) step();
        rx = 1'b1;
        repeat (400) step();
        check("glitch_still_waiting", cmd_ready, 0);
        check("glitch_no_rv", rv_total, rv0);
        check("glitch_tx_idle", tx, 1);
        expect_good_rx(rb);

        // cmd_valid held during a write: second command taken only after ready returns
        c1 = {1'b1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
        c2 = {1'b1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255))};
        send_cmd(c1, 1);
        cmd_data = c2;
        check_frames(c1);
        step();
        cmd_valid = 1'b0;
        check("second_accepted", cmd_ready, 0);
        check_frames(c2);
        check("second_rd_kept", read_data, rb);

        // Reset mid-frame during a zero bit
        send_cmd({1'b1, 7'd100, 8'hAB}, 0);
        repeat (BAUD + 100) step();
        check("pre_reset_tx_low", tx, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_rv", read_valid, 0);
        check("async_rst_rd", read_data, 0);
        step();
        rst_n = 1'b1;
        repeat (BAUD) step();
        check("post_rst_tx", tx, 1);
        check("post_rst_ready", cmd_ready, 1);
        $display("reset mid-frame: tx=%b cmd_ready=%b", tx, cmd_ready);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
